// File: rtl/wb_commit.sv
// wb_commit: last pipeline stage. Consumes the MEM/WB bundle and commits it
// to the GPR write port and the machine-mode CSR file (mcycle/minstret
// included). It also handles trap entry and mret, and raises a one-cycle
// flush with a redirect PC toward fetch.
module wb_commit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        wb_valid,
  input  logic        wb_wr_reg,
  input  logic [4:0]  wb_wr_regindex,
  input  logic [31:0] wb_wr_wdata,
  input  logic [31:0] wb_pc,
  input  logic        wb_exp,
  input  logic [4:0]  wb_causecode,
  input  logic [31:0] wb_mtval,
  input  logic        wb_mret,
  input  logic        wb_wr_csrreg,
  input  logic [11:0] wb_wr_csrindex,
  input  logic [31:0] wb_wr_csrwdata,
  input  logic [11:0] csr_rd_index,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] csr_rd_data,
  output logic        wb_flush,
  output logic [31:0] wb_redirect_pc,
  output logic        mstatus_mie
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;

  typedef enum logic {ST_IDLE, ST_SHADOW} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_commit, w_trap, w_mret, w_csr_we, w_retire;

  logic        r_mie, r_mpie;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [63:0] r_mcycle, r_minstret;
  logic        r_flush;
  logic [31:0] r_redirect_pc;

  // The PC's bit 0 is never stored because mepc is halfword aligned.
  logic        w_unused;
  assign w_unused = wb_pc[0];

  // State register: SHADOW marks the single wrong-path cycle after a redirect.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Commit qualification, the action decode, and the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_trap      = 1'b0;
    w_mret      = 1'b0;
    w_csr_we    = 1'b0;
    w_retire    = 1'b0;
    rf_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_commit = wb_valid;
        w_trap   = w_commit & wb_exp;
        w_mret   = w_commit & wb_mret & ~wb_exp;
        w_csr_we = w_commit & wb_wr_csrreg & ~wb_exp;
        w_retire = w_commit & ~wb_exp;
        rf_we    = w_commit & wb_wr_reg & ~wb_exp & (wb_wr_regindex != 5'd0);
        if (w_trap || w_mret) w_state_nxt = ST_SHADOW;
      end
      ST_SHADOW: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign rf_waddr = wb_wr_regindex;
  assign rf_wdata = wb_wr_wdata;

  // mstatus MIE/MPIE. A trap beats mret, and mret beats a CSR write.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (w_trap) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (w_mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_csr_we && wb_wr_csrindex == A_MSTATUS) begin
      r_mie  <= wb_wr_csrwdata[3];
      r_mpie <= wb_wr_csrwdata[7];
    end
  end

  // Software-only CSRs: mtvec (direct mode only) and mscratch.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      r_mtvec    <= RESET_MTVEC;
      r_mscratch <= 32'd0;
    end else if (w_csr_we) begin
      if (wb_wr_csrindex == A_MTVEC)    r_mtvec    <= {wb_wr_csrwdata[31:2], 2'b00};
      if (wb_wr_csrindex == A_MSCRATCH) r_mscratch <= wb_wr_csrwdata;
    end
  end

  // Trap CSRs: trap entry captures them, and otherwise software can write them.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      r_mepc   <= 32'd0;
      r_mcause <= 32'd0;
      r_mtval  <= 32'd0;
    end else if (w_trap) begin
      r_mepc   <= {wb_pc[31:1], 1'b0};
      r_mcause <= {27'd0, wb_causecode};
      r_mtval  <= wb_mtval;
    end else if (w_csr_we) begin
      if (wb_wr_csrindex == A_MEPC)   r_mepc   <= {wb_wr_csrwdata[31:1], 1'b0};
      if (wb_wr_csrindex == A_MCAUSE) r_mcause <= wb_wr_csrwdata;
      if (wb_wr_csrindex == A_MTVAL)  r_mtval  <= wb_wr_csrwdata;
    end
  end

  // mcycle: a write to one half replaces that cycle's increment, with no carry.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst)                                        r_mcycle        <= 64'd0;
    else if (w_csr_we && wb_wr_csrindex == A_MCYCLE)   r_mcycle[31:0]  <= wb_wr_csrwdata;
    else if (w_csr_we && wb_wr_csrindex == A_MCYCLEH)  r_mcycle[63:32] <= wb_wr_csrwdata;
    else                                               r_mcycle        <= r_mcycle + 64'd1;
  end

  // minstret: counts non-excepting commits. A half write wins, as for mcycle.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst)                                        r_minstret        <= 64'd0;
    else if (w_csr_we && wb_wr_csrindex == A_MINSTR)   r_minstret[31:0]  <= wb_wr_csrwdata;
    else if (w_csr_we && wb_wr_csrindex == A_MINSTRH)  r_minstret[63:32] <= wb_wr_csrwdata;
    else if (w_retire)                                 r_minstret        <= r_minstret + 64'd1;
  end

  // Flush and redirect. The target is the pre-edge mtvec or mepc.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_flush <= w_trap | w_mret;
      if (w_trap)      r_redirect_pc <= r_mtvec;
      else if (w_mret) r_redirect_pc <= r_mepc;
    end
  end

  assign wb_flush       = r_flush;
  assign wb_redirect_pc = r_redirect_pc;
  assign mstatus_mie    = r_mie;

  // CSR read port. It shows pre-edge state; there is no bypass.
  always_comb begin
    csr_rd_data = 32'd0;
    case (csr_rd_index)
      A_MSTATUS:  csr_rd_data = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
      A_MTVEC:    csr_rd_data = r_mtvec;
      A_MSCRATCH: csr_rd_data = r_mscratch;
      A_MEPC:     csr_rd_data = r_mepc;
      A_MCAUSE:   csr_rd_data = r_mcause;
      A_MTVAL:    csr_rd_data = r_mtval;
      A_MCYCLE:   csr_rd_data = r_mcycle[31:0];
      A_MCYCLEH:  csr_rd_data = r_mcycle[63:32];
      A_MINSTR:   csr_rd_data = r_minstret[31:0];
      A_MINSTRH:  csr_rd_data = r_minstret[63:32];
      default:    csr_rd_data = 32'd0;
    endcase
  end

endmodule
